// File: rtl/radix_4_otf_quotient_converter.sv
// Radix-4 on-the-fly quotient converter for the SRT divider.
// Two registers are kept in step, Q and QM = Q-1. Each signed digit is then
// absorbed by shifting one of them left and appending two bits, so no carry
// chain is needed per digit. The final remainder sign selects Q or QM.
module radix_4_otf_quotient_converter #(
    parameter int WIDTH = 32,
    localparam int ITERS = WIDTH / 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             digit_valid_i,
    input  logic [4:0]       digit_i,
    input  logic             rem_valid_i,
    input  logic             rem_neg_i,
    output logic             done_valid_o,
    input  logic             done_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic             err_o
);

    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

    typedef enum logic [1:0] {IDLE, ITER, CORR, DONE} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   q_reg, q_next;
    logic [WIDTH-1:0]   qm_reg, qm_next;
    logic [WIDTH-1:0]   quot_reg, quot_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               err_reg, err_next;

    logic               digit_legal;
    logic [2:0]         d_val;
    logic               d_pos;
    logic               d_neg;
    logic [1:0]         q_low;
    logic [1:0]         qm_low;
    logic [WIDTH-1:0]   q_app;
    logic [WIDTH-1:0]   qm_app;
    logic               start_fire;

    // Decode the one-hot digit into a 3-bit two's-complement value; anything
    // that is not exactly one-hot is absorbed as a zero digit.
    always_comb begin
        digit_legal = $onehot(digit_i);
        d_val       = 3'b000;
        case (digit_i)
            5'b10000: d_val = 3'b110;   // -2
            5'b01000: d_val = 3'b111;   // -1
            5'b00010: d_val = 3'b001;   // +1
            5'b00001: d_val = 3'b010;   // +2
            default:  d_val = 3'b000;   //  0 or illegal
        endcase
    end

    // Appended digit bits: d mod 4 for Q and (d-1) mod 4 for QM. Which
    // register supplies the upper bits depends only on the digit's sign.
    assign d_neg  = d_val[2];
    assign d_pos  = !d_val[2] && (d_val != 3'b000);
    assign q_low  = d_val[1:0];
    assign qm_low = d_val[1:0] - 2'd1;

    assign q_app[1:0]  = q_low;
    assign qm_app[1:0] = qm_low;

    generate
        for (genvar gi = 0; gi < WIDTH - 2; gi++) begin : g_shift
            assign q_app[gi+2]  = d_neg ? qm_reg[gi] : q_reg[gi];
            assign qm_app[gi+2] = d_pos ? q_reg[gi]  : qm_reg[gi];
        end
    endgenerate

    // Handshake outputs come from registered state; the only input term is
    // the back-to-back acceptance of start while the result is being taken.
    assign done_valid_o  = (state_reg == DONE);
    assign start_ready_o = (state_reg == IDLE) || ((state_reg == DONE) && done_ready_i);
    assign start_fire    = start_valid_i && start_ready_o;
    assign quot_o        = quot_reg;
    assign err_o         = err_reg;

    // Next-state and datapath update; flush overrides every other request.
    always_comb begin
        state_next = state_reg;
        q_next     = q_reg;
        qm_next    = qm_reg;
        quot_next  = quot_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;

        if (flush_i) begin
            state_next = IDLE;
            err_next   = 1'b0;
        end else begin
            case (state_reg)
                ITER: begin
                    if (digit_valid_i) begin
                        q_next   = q_app;
                        qm_next  = qm_app;
                        cnt_next = cnt_reg - CNT_W'(1);
                        if (!digit_legal) begin
                            err_next = 1'b1;
                        end
                        if (cnt_reg == '0) begin
                            state_next = CORR;
                        end
                    end
                end
                CORR: begin
                    if (rem_valid_i) begin
                        quot_next  = rem_neg_i ? qm_reg : q_reg;
                        state_next = DONE;
                    end
                end
                DONE: begin
                    if (done_ready_i) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase

            // A fresh conversion starts from Q = 0, QM = -1.
            if (start_fire) begin
                state_next = ITER;
                q_next     = '0;
                qm_next    = '1;
                cnt_next   = CNT_W'(ITERS - 1);
                err_next   = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset to the idle, empty condition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            q_reg     <= '0;
            qm_reg    <= '1;
            quot_reg  <= '0;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            q_reg     <= q_next;
            qm_reg    <= qm_next;
            quot_reg  <= quot_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

endmodule

// File: tb/tb_radix_4_otf_quotient_converter.sv
// Self-checking bench for the radix-4 OTF quotient converter (WIDTH = 8).
// A value-level model accumulates the quotient as an integer and is compared
// against the DUT every cycle; directed runs pin literal results.
module tb_radix_4_otf_quotient_converter;

    localparam int W = 8;
    localparam int N = W / 2;

    localparam logic [4:0] M2 = 5'b10000;
    localparam logic [4:0] M1 = 5'b01000;
    localparam logic [4:0] Z0 = 5'b00100;
    localparam logic [4:0] P1 = 5'b00010;
    localparam logic [4:0] P2 = 5'b00001;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush_i = 1'b0;
    logic         start_valid_i = 1'b0;
    logic         start_ready_o;
    logic         digit_valid_i = 1'b0;
    logic [4:0]   digit_i = 5'b0;
    logic         rem_valid_i = 1'b0;
    logic         rem_neg_i = 1'b0;
    logic         done_valid_o;
    logic         done_ready_i = 1'b0;
    logic [W-1:0] quot_o;
    logic         err_o;

    radix_4_otf_quotient_converter #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .start_valid_i (start_valid_i),
        .start_ready_o (start_ready_o),
        .digit_valid_i (digit_valid_i),
        .digit_i       (digit_i),
        .rem_valid_i   (rem_valid_i),
        .rem_neg_i     (rem_neg_i),
        .done_valid_o  (done_valid_o),
        .done_ready_i  (done_ready_i),
        .quot_o        (quot_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    int t_start = 0;

    // Model: conversion progress and the quotient as a plain integer.
    bit m_busy = 0, m_await = 0, m_pend = 0, m_err = 0, m_res_ok = 1;
    int m_left = 0, m_acc = 0, m_res = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int dec(input logic [4:0] g);
        case (g)
            M2: return -2;
            M1: return -1;
            P1: return 1;
            P2: return 2;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 0; m_await = 0; m_pend = 0; m_err = 0;
        m_left = 0; m_acc = 0; m_res = 0; m_res_ok = 1;
    endtask

    // Model update on each rising edge from the inputs present at that edge.
    initial begin
        forever begin
            bit idle, sf;
            @(posedge clk);
            cyc = cyc + 1;
            if (rst) begin
                model_reset();
            end else if (flush_i) begin
                m_busy = 0; m_await = 0; m_pend = 0; m_err = 0; m_res_ok = 0;
            end else begin
                idle = !m_busy && !m_await && !m_pend;
                sf = start_valid_i && (idle || (m_pend && done_ready_i));
                if (m_pend && done_ready_i) begin
                    m_pend = 0;
                end else if (m_busy && digit_valid_i) begin
                    if ($countones(digit_i) != 1) m_err = 1;
                    m_acc = (m_acc * 4 + dec(digit_i)) & 255;
                    m_left--;
                    if (m_left == 0) begin
                        m_busy = 0;
                        m_await = 1;
                    end
                end else if (m_await && rem_valid_i) begin
                    m_res = (m_acc - int'(rem_neg_i)) & 255;
                    m_await = 0;
                    m_pend = 1;
                    m_res_ok = 1;
                end
                if (sf) begin
                    m_acc = 0; m_left = N; m_busy = 1; m_err = 0;
                end
            end
        end
    end

    // Compare process: checks every output on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) model_reset();
            chk("start_ready", 32'(start_ready_o),
                32'((!m_busy && !m_await && !m_pend) || (m_pend && done_ready_i)));
            chk("done_valid", 32'(done_valid_o), 32'(m_pend));
            chk("err", 32'(err_o), 32'(m_err));
            if (m_res_ok) chk("quot", 32'(quot_o), m_res);
            if (m_busy || m_await) begin
                chk("q_track", 32'(dut.q_reg), m_acc & 255);
                chk("qm_is_q_minus_1", 32'(dut.qm_reg), (m_acc - 1) & 255);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        int k = 0;
        start_valid_i = 1'b1;
        while (!start_ready_o && k < 20) begin
            step();
            k++;
        end
        if (k == 20) chk("start_timeout", 0, 1);
        t_start = cyc;
        step();
        start_valid_i = 1'b0;
    endtask

    // One conversion: digits first-to-last from the top of dg, gap idle
    // cycles before each digit, rdly cycles of back-pressure on the result.
    task automatic conv(input logic [19:0] dg, input bit neg, input int gap, input int rdly,
                        input bit use_exp, input logic [7:0] exp, input string nm,
                        input bit started, input bit b2b_next, input bit noise);
        int k = 0;
        if (!started) do_start();
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gap; g++) begin
                rem_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
            end
            rem_valid_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            digit_valid_i = 1'b1;
            digit_i = dg[19-5*i -: 5];
            step();
            digit_valid_i = 1'b0;
        end
        if (noise) begin
            rem_valid_i = 1'b0;
            digit_valid_i = 1'b1;
            digit_i = P2;
            step();
            digit_valid_i = 1'b0;
        end
        rem_valid_i = 1'b1;
        rem_neg_i = neg;
        step();
        rem_valid_i = 1'b0;
        while (!done_valid_o && k < 8) begin
            step();
            k++;
        end
        if (k == 8) chk({nm, "_done_timeout"}, 0, 1);
        if (use_exp) begin
            chk({nm, "_quot"}, 32'(quot_o), 32'(exp));
            if (gap == 0 && !noise) chk({nm, "_latency"}, cyc - t_start, N + 2);
        end
        for (int r = 0; r < rdly; r++) step();
        done_ready_i = 1'b1;
        start_valid_i = b2b_next;
        if (b2b_next) t_start = cyc;
        step();
        done_ready_i = 1'b0;
        start_valid_i = 1'b0;
    endtask

    function automatic logic [4:0] rand_digit();
        logic [4:0] tbl [5];
        tbl[0] = M2; tbl[1] = M1; tbl[2] = Z0; tbl[3] = P1; tbl[4] = P2;
        if ($urandom_range(0, 9) == 0) return 5'($urandom_range(0, 31));
        return tbl[$urandom_range(0, 4)];
    endfunction

    initial begin
        bit b2b;
        logic [19:0] rd;
        step();
        step();
        rst = 1'b0;
        chk("reset_start_ready", 32'(start_ready_o), 1);
        chk("reset_done_valid", 32'(done_valid_o), 0);
        chk("reset_quot", 32'(quot_o), 0);
        chk("reset_err", 32'(err_o), 0);

        conv({P1, P2, M1, Z0}, 0, 0, 0, 1, 8'h5C, "basic", 0, 0, 0);
        chk("basic_err", 32'(err_o), 0);
        conv({P1, P2, M1, Z0}, 1, 0, 0, 1, 8'h5B, "neg_corr", 0, 0, 0);
        conv({M1, Z0, Z0, Z0}, 0, 0, 0, 1, 8'hC0, "m1_top", 0, 0, 0);
        conv({P2, P2, P2, P2}, 0, 0, 0, 1, 8'hAA, "all_p2", 0, 0, 0);
        conv({M2, M2, M2, M2}, 1, 0, 0, 1, 8'h55, "all_m2", 0, 0, 0);
        conv({P1, P2, M1, Z0}, 0, 3, 5, 1, 8'h5C, "gaps", 0, 0, 0);

        // Illegal digit is absorbed as zero and flags err until next start.
        conv({P1, 5'b00011, P1, P1}, 0, 0, 2, 1, 8'h45, "illegal", 0, 0, 0);
        do_start();
        chk("err_cleared_by_start", 32'(err_o), 0);
        conv({P1, P1, P1, P1}, 0, 0, 0, 1, 8'h55, "after_err", 1, 0, 0);

        // Back-to-back: the result handshake also accepts the next start.
        conv({P1, P2, M1, Z0}, 0, 0, 0, 1, 8'h5C, "b2b_first", 0, 1, 0);
        chk("b2b_no_bubble_ready", 32'(start_ready_o), 0);
        chk("b2b_no_bubble_done", 32'(done_valid_o), 0);
        conv({P2, P2, P2, P2}, 0, 0, 0, 1, 8'hAA, "b2b_second", 1, 0, 0);

        // Flush mid-conversion.
        do_start();
        digit_valid_i = 1'b1; digit_i = 5'b11000; step();
        digit_i = P1; step();
        digit_valid_i = 1'b0;
        flush_i = 1'b1; step(); flush_i = 1'b0;
        chk("flush_start_ready", 32'(start_ready_o), 1);
        chk("flush_done_valid", 32'(done_valid_o), 0);
        chk("flush_err", 32'(err_o), 0);

        // Asynchronous reset after two digits.
        do_start();
        digit_valid_i = 1'b1; digit_i = 5'b00000; step();
        digit_i = P2; step();
        digit_valid_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("arst_done_valid", 32'(done_valid_o), 0);
        chk("arst_start_ready", 32'(start_ready_o), 1);
        chk("arst_err", 32'(err_o), 0);
        chk("arst_q", 32'(dut.q_reg), 0);
        chk("arst_qm", 32'(dut.qm_reg), 32'hFF);
        chk("arst_quot", 32'(quot_o), 0);
        step();
        rst = 1'b0;
        conv({P1, P2, M1, Z0}, 0, 0, 0, 1, 8'h5C, "after_rst", 0, 0, 0);

        // Randomized conversions checked by the model.
        b2b = 0;
        for (int n = 0; n < 40; n++) begin
            bit nb;
            rd = {rand_digit(), rand_digit(), rand_digit(), rand_digit()};
            nb = ($urandom_range(0, 3) == 0);
            conv(rd, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3),
                 0, 8'h00, "rand", b2b, nb, 1'($urandom_range(0, 1)));
            b2b = nb;
        end
        if (b2b) conv({Z0, Z0, Z0, P1}, 1, 0, 0, 1, 8'h00, "rand_tail", 1, 0, 0);

        repeat (3) step();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
